// File: rtl/tt_um_host_driver.sv
// tt_um_host_driver
// Host-side driver for a single tt_um user-design slot. Accepts ENABLE /
// DRIVE / DISABLE commands over a valid/ready port, sequences the slot
// enable, reset and clock-enable, applies input vectors and returns the
// captured outputs over a valid/ready response port. While the slot is
// disabled, it holds ui/uio inputs at zero, keeps the design in reset and
// stops the clock.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   cmd_valid/ready/op/ui/uio command channel (op: 0 EN, 1 DRIVE, 2 DIS, 3 nop)
//   rsp_valid/ready/uo/uio/oe response channel with captured slot outputs
//   err                       sticky: DRIVE seen while the slot was disabled
//   um_*                      slot side: ena, clock-gate enable, reset, ui/uio
//
// state   | meaning
// OFF     | slot disabled, inputs zero, in reset, clock stopped
// RSTHOLD | slot enabled and clocked, reset held low for RST_CYCLES
// READY   | slot running, waiting for a command
// RUN     | vector applied, waiting LATENCY clocked cycles before capture
// RESP    | response valid, waiting for rsp_ready
module tt_um_host_driver #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_ui,
  input  logic [7:0] cmd_uio,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_uo,
  output logic [7:0] rsp_uio,
  output logic [7:0] rsp_oe,
  output logic       err,
  output logic       um_ena,
  output logic       um_clk_en,
  output logic       um_rst_n,
  output logic [7:0] um_ui_in,
  output logic [7:0] um_uio_in,
  input  logic [7:0] um_uo_out,
  input  logic [7:0] um_uio_out,
  input  logic [7:0] um_uio_oe
);

  typedef enum logic [2:0] {
    S_OFF, S_RSTHOLD, S_READY, S_RUN, S_RESP
  } state_e;

  localparam logic [1:0] OP_ENABLE  = 2'd0;
  localparam logic [1:0] OP_DRIVE   = 2'd1;
  localparam logic [1:0] OP_DISABLE = 2'd2;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ui_q, ui_d;
  logic [7:0] uio_q, uio_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_uo_q, rsp_uo_d;
  logic [7:0] rsp_uio_q, rsp_uio_d;
  logic [7:0] rsp_oe_q, rsp_oe_d;
  logic       err_q, err_d;
  logic       accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      ui_q        <= '0;
      uio_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_uo_q    <= '0;
      rsp_uio_q   <= '0;
      rsp_oe_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_uo_q    <= rsp_uo_d;
      rsp_uio_q   <= rsp_uio_d;
      rsp_oe_q    <= rsp_oe_d;
      err_q       <= err_d;
    end
  end

  assign accept = cmd_valid && cmd_ready;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ui_d        = ui_q;
    uio_d       = uio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_uo_d    = rsp_uo_q;
    rsp_uio_d   = rsp_uio_q;
    rsp_oe_d    = rsp_oe_q;
    err_d       = err_q;
    case (state_q)
      S_OFF: begin
        if (accept) begin
          if (cmd_op == OP_ENABLE) begin
            state_d = S_RSTHOLD;
            cnt_d   = RST_LOAD;
            err_d   = 1'b0;
          end else if (cmd_op == OP_DRIVE) begin
            err_d = 1'b1;
          end
        end
      end
      S_RSTHOLD: begin
        // Leaving on the count of 1 keeps reset low for exactly RST_CYCLES.
        if (cnt_q <= 8'd1) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_READY: begin
        if (accept) begin
          case (cmd_op)
            OP_ENABLE: begin
              state_d = S_RSTHOLD;
              cnt_d   = RST_LOAD;
              err_d   = 1'b0;
            end
            OP_DRIVE: begin
              state_d = S_RUN;
              cnt_d   = LAT_LOAD;
              ui_d    = cmd_ui;
              uio_d   = cmd_uio;
            end
            OP_DISABLE: begin
              state_d = S_OFF;
              ui_d    = '0;
              uio_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Capture after LATENCY full clocked cycles past the vector edge.
        if (cnt_q == 8'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_uo_d    = um_uo_out;
          rsp_uio_d   = um_uio_out;
          rsp_oe_d    = um_uio_oe;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_READY;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready = (state_q == S_OFF) || (state_q == S_READY);
    um_ena    = (state_q != S_OFF);
    um_clk_en = (state_q != S_OFF);
    um_rst_n  = (state_q == S_READY) || (state_q == S_RUN) || (state_q == S_RESP);
    um_ui_in  = um_ena ? ui_q : 8'h00;
    um_uio_in = um_ena ? ((um_uio_oe & um_uio_out) | (~um_uio_oe & uio_q)) : 8'h00;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_uo    = rsp_uo_q;
  assign rsp_uio   = rsp_uio_q;
  assign rsp_oe    = rsp_oe_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tt_um_host_driver.sv
module tb_tt_um_host_driver;

  localparam int RST_CYCLES = 4;
  localparam int LATENCY    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_ui, cmd_uio;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_uo, rsp_uio, rsp_oe;
  logic       err;
  logic       um_ena, um_clk_en, um_rst_n;
  logic [7:0] um_ui_in, um_uio_in, um_uo_out, um_uio_out, um_uio_oe;

  // user-design stand-in: uo = ~ui, uio_out / oe set by the test
  logic [7:0] cfg_oe, cfg_uout;
  assign um_uo_out  = ~um_ui_in;
  assign um_uio_out = cfg_uout;
  assign um_uio_oe  = cfg_oe;

  int n_chk  = 0;
  int n_pass = 0;

  tt_um_host_driver #(.RST_CYCLES(RST_CYCLES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ui(cmd_ui), .cmd_uio(cmd_uio),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_uo(rsp_uo), .rsp_uio(rsp_uio), .rsp_oe(rsp_oe), .err(err),
    .um_ena(um_ena), .um_clk_en(um_clk_en), .um_rst_n(um_rst_n),
    .um_ui_in(um_ui_in), .um_uio_in(um_uio_in),
    .um_uo_out(um_uo_out), .um_uio_out(um_uio_out), .um_uio_oe(um_uio_oe)
  );

  always #5 clk = ~clk;

  // reference: each uio_in bit loops back the user output when the user drives it
  function automatic logic [7:0] ref_uio_in(input logic [7:0] host, oe, uout);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = oe[b] ? uout[b] : host[b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one command, wait (bounded) for acceptance; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [7:0] ui, input logic [7:0] uio);
    bit ok = 0;
    cmd_op = op; cmd_ui = ui; cmd_uio = uio; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready) ok = 1;
      tick();
    end
    cmd_valid = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL cmd_accept_timeout op=%0d got no cmd_ready, wanted ready", op);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_ui = 0; cmd_uio = 0; rsp_ready = 0;
    cfg_oe = 8'hFF; cfg_uout = 8'hFF;
    repeat (3) tick();
    rst = 1'b0;
    n_chk++;
    if ({um_ena, um_clk_en, um_rst_n, um_ui_in, um_uio_in, rsp_valid, err, cmd_ready} !== {3'b000, 16'h0, 3'b001})
      $display("FAIL reset_state got ena=%b clk_en=%b rst_n=%b ui=%h uio=%h rv=%b err=%b rdy=%b",
               um_ena, um_clk_en, um_rst_n, um_ui_in, um_uio_in, rsp_valid, err, cmd_ready);
    else n_pass++;
    n_chk++;
    if ({rsp_uo, rsp_uio, rsp_oe} !== 24'h0) $display("FAIL reset_rsp got %h wanted 000000", {rsp_uo, rsp_uio, rsp_oe});
    else n_pass++;
  endtask

  task automatic test_enable();
    int low_cnt = 0;
    bit hold_ready = 0;
    send(2'd0, 8'h00, 8'h00);
    n_chk++;
    if ({um_ena, um_clk_en, um_rst_n, cmd_ready} !== 4'b1100)
      $display("FAIL enable_first got ena=%b clk_en=%b rst_n=%b rdy=%b wanted 1 1 0 0", um_ena, um_clk_en, um_rst_n, cmd_ready);
    else n_pass++;
    for (int i = 0; i < 20 && !um_rst_n; i++) begin
      low_cnt++;
      if (cmd_ready) hold_ready = 1;
      tick();
    end
    n_chk++;
    if (low_cnt != RST_CYCLES) $display("FAIL rst_hold_len got %0d wanted %0d", low_cnt, RST_CYCLES);
    else n_pass++;
    n_chk++;
    if (hold_ready || !cmd_ready || !um_ena) $display("FAIL rst_hold_ready got hold_ready=%b rdy_after=%b ena=%b wanted 0 1 1", hold_ready, cmd_ready, um_ena);
    else n_pass++;
  endtask

  // One DRIVE transaction against the reference; hold = cycles of rsp backpressure.
  task automatic do_drive(input logic [7:0] ui, uio, oe, uout, input int hold);
    int lat = 0;
    logic [7:0] s_uo, s_uio, s_oe;
    bit stable = 1;
    cfg_oe = oe; cfg_uout = uout; rsp_ready = 1'b0;
    send(2'd1, ui, uio);
    n_chk++;
    if (um_uio_in !== ref_uio_in(uio, oe, uout) || um_ui_in !== ui)
      $display("FAIL drive_apply got ui=%h uio_in=%h wanted ui=%h uio_in=%h", um_ui_in, um_uio_in, ui, ref_uio_in(uio, oe, uout));
    else n_pass++;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    n_chk++;
    if (lat != LATENCY + 1) $display("FAIL drive_latency got %0d wanted %0d", lat, LATENCY + 1);
    else n_pass++;
    n_chk++;
    if ({rsp_uo, rsp_uio, rsp_oe} !== {~ui, uout, oe})
      $display("FAIL drive_rsp got uo=%h uio=%h oe=%h wanted uo=%h uio=%h oe=%h", rsp_uo, rsp_uio, rsp_oe, ~ui, uout, oe);
    else n_pass++;
    s_uo = rsp_uo; s_uio = rsp_uio; s_oe = rsp_oe;
    for (int i = 0; i < hold; i++) begin
      cfg_uout = 8'($urandom);
      if (!rsp_valid || cmd_ready || {rsp_uo, rsp_uio, rsp_oe} !== {s_uo, s_uio, s_oe}) stable = 0;
      tick();
    end
    cfg_uout = uout;
    n_chk++;
    if (!stable || !rsp_valid || cmd_ready) $display("FAIL rsp_hold got stable=%b valid=%b rdy=%b wanted 1 1 0", stable, rsp_valid, cmd_ready);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid || !cmd_ready || um_ui_in !== ui)
      $display("FAIL rsp_release got valid=%b rdy=%b ui=%h wanted 0 1 %h", rsp_valid, cmd_ready, um_ui_in, ui);
    else n_pass++;
  endtask

  task automatic test_drive_directed();
    do_drive(8'hA5, 8'h3C, 8'h0F, 8'h09, 0);
  endtask

  task automatic test_backpressure();
    do_drive(8'h5C, 8'hC3, 8'hF0, 8'h6E, 10);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++)
      do_drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_reserved();
    send(2'd3, 8'h00, 8'h00);
    n_chk++;
    if (!cmd_ready || rsp_valid || !um_rst_n) $display("FAIL reserved_nop got rdy=%b rv=%b rst_n=%b wanted 1 0 1", cmd_ready, rsp_valid, um_rst_n);
    else n_pass++;
  endtask

  task automatic test_disable();
    do_drive(8'hFF, 8'hFF, 8'h00, 8'h00, 0);
    cfg_oe = 8'hFF; cfg_uout = 8'hFF;
    send(2'd2, 8'h00, 8'h00);
    n_chk++;
    if ({um_ena, um_clk_en, um_rst_n, um_ui_in, um_uio_in} !== 19'h0)
      $display("FAIL disable_outputs got ena=%b clk_en=%b rst_n=%b ui=%h uio=%h wanted all 0", um_ena, um_clk_en, um_rst_n, um_ui_in, um_uio_in);
    else n_pass++;
  endtask

  task automatic test_drive_off();
    bit bad = 0;
    send(2'd1, 8'h12, 8'h34);
    n_chk++;
    if (err !== 1'b1 || um_ena !== 1'b0) $display("FAIL drive_off_err got err=%b ena=%b wanted 1 0", err, um_ena);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || um_ena || !err) bad = 1;
      tick();
    end
    n_chk++;
    if (bad) $display("FAIL drive_off_quiet got spurious response/enable or err dropped");
    else n_pass++;
    send(2'd0, 8'h00, 8'h00);
    n_chk++;
    if (err !== 1'b0 || um_ena !== 1'b1) $display("FAIL enable_clears_err got err=%b ena=%b wanted 0 1", err, um_ena);
    else n_pass++;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
  endtask

  task automatic test_rst_in_run();
    bit late = 0;
    cfg_oe = 8'h00; cfg_uout = 8'h00;
    send(2'd1, 8'h0F, 8'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({um_ena, um_clk_en, um_rst_n, um_ui_in, um_uio_in, rsp_valid, err, cmd_ready} !== {3'b000, 16'h0, 3'b001})
      $display("FAIL rst_in_run got ena=%b clk_en=%b rst_n=%b ui=%h uio=%h rv=%b err=%b rdy=%b",
               um_ena, um_clk_en, um_rst_n, um_ui_in, um_uio_in, rsp_valid, err, cmd_ready);
    else n_pass++;
    n_chk++;
    if ({rsp_uo, rsp_uio, rsp_oe} !== 24'h0) $display("FAIL rst_in_run_rsp got %h wanted 000000", {rsp_uo, rsp_uio, rsp_oe});
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || um_ena) late = 1;
      tick();
    end
    n_chk++;
    if (late) $display("FAIL rst_in_run_late got late response or enable after reset");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_drive_directed();
    test_backpressure();
    test_random();
    test_reserved();
    test_disable();
    test_drive_off();
    do_drive(8'h81, 8'h7E, 8'h3C, 8'hC3, 1);
    test_rst_in_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_um_host_driver.md
Name: tt_um_host_driver

Overview:
Host-side driver for one tt_um user-design slot; it owns the other end of the ena/clk/rst_n/ui/uio interface that user modules implement. It accepts commands over a valid/ready port to enable a design, run a reset sequence, apply input vectors and capture outputs. It also disables the design. While the slot is disabled, the block guarantees the slot contract: inputs zero, design held in reset, no clock. It sits between the test/controller logic and the mux slot.

Parameters:
RST_CYCLES, 4, cycles um_rst_n is held low after enable (1..255)
LATENCY, 2, clock-enabled cycles between applying a vector and capturing outputs (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=ENABLE, 1=DRIVE, 2=DISABLE, 3=reserved (accepted, no-op)
cmd_ui  in  8  ui_in vector for DRIVE
cmd_uio  in  8  uio_in vector for DRIVE (bits where oe=0)
rsp_valid  out  1  capture response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_uo  out  8  captured uo_out
rsp_uio  out  8  captured uio_out
rsp_oe  out  8  captured uio_oe
err  out  1  sticky: DRIVE received while disabled; cleared by ENABLE or rst
um_ena  out  1  slot enable
um_clk_en  out  1  clock-gate enable for the slot clock (gate is external)
um_rst_n  out  1  slot reset, active-low
um_ui_in  out  8  to user ui_in
um_uio_in  out  8  to user uio_in
um_uo_out  in  8  from user uo_out
um_uio_out  in  8  from user uio_out
um_uio_oe  in  8  from user uio_oe

Behaviour:
- rst: state OFF. um_ena=0, um_clk_en=0, um_rst_n=0, um_ui_in=0. Internal uio register=0. rsp_valid=0, rsp_* =0, err=0, counter=0.
- FSM states: OFF, RSTHOLD, READY, RUN, RESP.
- OFF: cmd_ready=1. ENABLE -> RSTHOLD; um_ena=1 and um_clk_en=1 from the next cycle, um_rst_n stays 0, counter loaded with RST_CYCLES. DRIVE sets err=1 and stays OFF. DISABLE and reserved ops are no-ops.
- RSTHOLD: cmd_ready=0. Counter decrements each cycle. When it reaches 0, go to READY with um_rst_n=1. um_rst_n is therefore low for exactly RST_CYCLES cycles with the clock running.
- READY: cmd_ready=1.
  - DRIVE: register cmd_ui to um_ui_in and cmd_uio to the internal uio register, load counter with LATENCY, go to RUN.
  - DISABLE: go to OFF. Next cycle um_ena=0, um_clk_en=0, um_rst_n=0, um_ui_in=0, uio register=0.
  - ENABLE: re-runs the reset sequence (-> RSTHOLD).
  - Reserved op: no-op.
- RUN: cmd_ready=0. Counter decrements. At 0, sample um_uo_out, um_uio_out and um_uio_oe into rsp_*, set rsp_valid=1, go to RESP.
- RESP: cmd_ready=0. rsp_* are stable while rsp_valid=1. On rsp_ready, drop rsp_valid and go to READY. um_ui_in keeps its last vector until the next DRIVE or DISABLE.
- um_uio_in is combinational, per bit: if um_ena=0, output 0. Otherwise, if um_uio_oe[i]=1, output um_uio_out[i] (loopback); else output the uio register bit.
- Invariant, every cycle: um_ena=0 implies um_ui_in=0, um_uio_in=0, um_rst_n=0 and um_clk_en=0.
- Latency: command accepted at edge N; the response is visible at edge N+LATENCY+1 for DRIVE.
- Single outstanding command. There is no command queue and cmd_ready is deasserted from RSTHOLD through RESP. DISABLE is only accepted in OFF or READY.
- rst asserted in any state returns to OFF on the next edge. The reset values above override the FSM, including in the middle of RUN and with rsp_valid high.
- err is sticky across DRIVE/DISABLE and cleared only by ENABLE acceptance or rst.

Test Plan:
- rst, then ENABLE with RST_CYCLES=4 -> um_ena=1 and um_clk_en=1 the cycle after acceptance; um_rst_n=0 for exactly 4 cycles, then 1; cmd_ready low during the hold.
- After enable, DRIVE ui=0xA5, uio=0x3C with a model setting uo_out=~ui_in, oe=0x0F, uio_out=0x09 -> rsp_uo=0x5A, rsp_oe=0x0F, rsp_uio=0x09 after LATENCY+1 edges; um_uio_in=0x39 (upper nibble 0x3 from cmd, lower nibble 0x9 looped back).
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_* stable, cmd_ready=0; rsp_ready=1 -> READY and cmd_ready=1 next cycle.
- DISABLE after a DRIVE of ui=0xFF -> next cycle um_ena=0, um_clk_en=0, um_rst_n=0, um_ui_in=0x00, um_uio_in=0x00 even with uio_oe=0xFF from the model.
- DRIVE while OFF -> err=1, no response, no enable; subsequent ENABLE clears err.
- Assert rst during RUN -> next edge is OFF with all outputs at reset values and rsp_valid=0; no late response appears.
